// File: rtl/stream_mux_pkg.sv
// Shared definitions for stream_mux_n_to_one: arbitration mode encoding and
// channel-index wrap helper.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Wraps at the channel count, not at the index field width.
    function automatic int unsigned next_ch(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_to_one_rr_arbiter.sv
// Combinational priority search over a request vector, starting at ptr and
// wrapping at num_ch. Returns the first requesting index and a valid flag.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int num_ch    = 4,
    parameter int sel_width = $clog2(num_ch)
) (
    input  logic [num_ch-1:0]    req,
    input  logic [sel_width-1:0] ptr,
    output logic [sel_width-1:0] gnt_idx,
    output logic                 gnt_vld
);

    logic [sel_width-1:0] idx;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = ptr;
        for (int i = 0; i < num_ch; i++) begin
            if (!gnt_vld && req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
            idx = sel_width'(next_ch(32'(idx), num_ch));
        end
    end

endmodule

// File: rtl/stream_mux_n_to_one.sv
// N:1 stream mux with fixed-select or round-robin arbitration and a registered
// output stage. Define STREAM_MUX_PKT_LOCK_EN to add i_Last/o_Last packet locking.
module stream_mux_n_to_one
    import stream_mux_pkg::*;
#(
    parameter int bit_width = 8,
    parameter int num_ch    = 4,
    parameter int sel_width = $clog2(num_ch)
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    input  logic [num_ch*bit_width-1:0] i_Data,
    input  logic [num_ch-1:0]           i_Valid,
    output logic [num_ch-1:0]           o_Ready,
    input  logic                        i_Mode,
    input  logic [sel_width-1:0]        i_Sel,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [num_ch-1:0]           i_Last,
    output logic                        o_Last,
`endif
    output logic [bit_width-1:0]        o_Data,
    output logic                        o_Valid,
    output logic [sel_width-1:0]        o_Ch,
    input  logic                        i_Ready
);

    logic [num_ch-1:0]    req;
    logic [sel_width-1:0] gnt_idx;
    logic                 gnt_vld;
    logic                 load_en;
    logic                 xfer;

    logic [sel_width-1:0] rr_ptr_q, rr_ptr_d;
    logic [bit_width-1:0] o_data_q, o_data_d;
    logic [sel_width-1:0] o_ch_q, o_ch_d;
    logic                 o_valid_q, o_valid_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic                 lock_q, lock_d;
    logic [sel_width-1:0] lock_ch_q, lock_ch_d;
    logic                 o_last_q, o_last_d;
`endif

    // Fixed mode reuses the arbiter by presenting only the selected request.
    always_comb begin
        req = '0;
        if (i_Mode == MODE_RR) begin
            req = i_Valid;
        end else if (32'(i_Sel) < num_ch) begin
            req[i_Sel] = i_Valid[i_Sel];
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_q) begin
            req            = '0;
            req[lock_ch_q] = i_Valid[lock_ch_q];
        end
`endif
    end

    rr_arbiter #(
        .num_ch    (num_ch),
        .sel_width (sel_width)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign load_en = !o_valid_q || i_Ready;
    assign xfer    = load_en && gnt_vld && !i_Reset;

    always_comb begin
        o_Ready = '0;
        if (xfer) begin
            o_Ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_ch_d    = o_ch_q;
        rr_ptr_d  = rr_ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        o_last_d  = o_last_q;
`endif
        if (load_en) begin
            o_valid_d = gnt_vld;
        end
        if (xfer) begin
            o_data_d = i_Data[gnt_idx*bit_width +: bit_width];
            o_ch_d   = gnt_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
            o_last_d  = i_Last[gnt_idx];
            lock_d    = !i_Last[gnt_idx];
            lock_ch_d = gnt_idx;
            if (i_Mode == MODE_RR && i_Last[gnt_idx]) begin
                rr_ptr_d = sel_width'(next_ch(32'(gnt_idx), num_ch));
            end
`else
            if (i_Mode == MODE_RR) begin
                rr_ptr_d = sel_width'(next_ch(32'(gnt_idx), num_ch));
            end
`endif
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_ch_q    <= '0;
            rr_ptr_q  <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            o_last_q  <= 1'b0;
`endif
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_ch_q    <= o_ch_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            o_last_q  <= o_last_d;
`endif
        end
    end

    assign o_Valid = o_valid_q;
    assign o_Data  = o_data_q;
    assign o_Ch    = o_ch_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    assign o_Last  = o_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_n_to_one.sv
// Directed bench for stream_mux_n_to_one: a 4-channel and a 3-channel instance.
module tb_stream_mux_n_to_one;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        rst4, mode4, rdy4, ov4;
    logic [31:0] d4;
    logic [3:0]  v4, ordy4, last4;
    logic [1:0]  sel4, ch4;
    logic [7:0]  od4;
    logic        olast4;

    // 3-channel instance
    logic        rst3, mode3, rdy3, ov3;
    logic [23:0] d3;
    logic [2:0]  v3, ordy3, last3;
    logic [1:0]  sel3, ch3;
    logic [7:0]  od3;
    logic        olast3;

    stream_mux_n_to_one #(.bit_width(8), .num_ch(4)) dut4 (
        .i_Clk   (clk),
        .i_Reset (rst4),
        .i_Data  (d4),
        .i_Valid (v4),
        .o_Ready (ordy4),
        .i_Mode  (mode4),
        .i_Sel   (sel4),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .i_Last  (last4),
        .o_Last  (olast4),
`endif
        .o_Data  (od4),
        .o_Valid (ov4),
        .o_Ch    (ch4),
        .i_Ready (rdy4)
    );

    stream_mux_n_to_one #(.bit_width(8), .num_ch(3)) dut3 (
        .i_Clk   (clk),
        .i_Reset (rst3),
        .i_Data  (d3),
        .i_Valid (v3),
        .o_Ready (ordy3),
        .i_Mode  (mode3),
        .i_Sel   (sel3),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .i_Last  (last3),
        .o_Last  (olast3),
`endif
        .o_Data  (od3),
        .o_Valid (ov3),
        .o_Ch    (ch3),
        .i_Ready (rdy3)
    );

`ifndef STREAM_MUX_PKT_LOCK_EN
    assign olast4 = 1'b0;
    assign olast3 = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_seq [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst4 = 1'b1; mode4 = 1'b0; sel4 = 2'd2; rdy4 = 1'b1;
        v4 = 4'b1111; d4 = {8'h40, 8'h30, 8'h20, 8'h10}; last4 = 4'b1111;
        rst3 = 1'b1; mode3 = 1'b1; sel3 = 2'd0; rdy3 = 1'b1;
        v3 = 3'b000; d3 = {8'hA2, 8'hA1, 8'hA0}; last3 = 3'b111;

        // Reset held for 3 cycles with all channels valid
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_valid", 32'(ov4), 32'd0);
            check("rst_data", 32'(od4), 32'h00);
            check("rst_ready", 32'(ordy4), 32'b0000);
        end

        // Fixed select on channel 2
        rst4 = 1'b0;
        #1;
        check("fix_ready0", 32'(ordy4), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fix_valid", 32'(ov4), 32'd1);
            check("fix_data", 32'(od4), 32'h30);
            check("fix_ch", 32'(ch4), 32'd2);
            check("fix_ready", 32'(ordy4), 32'b0100);
        end

        // Round-robin over all four channels, pointer still at 0
        mode4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_valid", 32'(ov4), 32'd1);
            check("rr_ch", 32'(ch4), 32'(rr_seq[i]));
            check("rr_data", 32'(od4), 32'((rr_seq[i] + 1) * 16));
        end

        // Backpressure while holding channel 1 / 0x20
        rdy4 = 1'b0;
        #1;
        check("bp_ready0", 32'(ordy4), 32'b0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid", 32'(ov4), 32'd1);
            check("bp_data", 32'(od4), 32'h20);
            check("bp_ch", 32'(ch4), 32'd1);
            check("bp_ready", 32'(ordy4), 32'b0000);
        end
        rdy4 = 1'b1;
        #1;
        check("bp_release_ready", 32'(ordy4), 32'b0100);
        tick();
        check("bp_next_ch", 32'(ch4), 32'd2);
        check("bp_next_data", 32'(od4), 32'h30);

        // No valid input: o_Valid drops, data/ch hold
        v4 = 4'b0000;
        tick();
        check("idle_valid", 32'(ov4), 32'd0);
        check("idle_data", 32'(od4), 32'h30);
        check("idle_ch", 32'(ch4), 32'd2);

        // Mid-operation reset drops the held beat
        v4 = 4'b1111; rdy4 = 1'b0;
        tick();
        check("pre_rst_valid", 32'(ov4), 32'd1);
        rst4 = 1'b1;
        tick();
        check("midrst_valid", 32'(ov4), 32'd0);
        check("midrst_data", 32'(od4), 32'h00);
        rst4 = 1'b0; rdy4 = 1'b1;
        tick();
        check("midrst_ptr0_ch", 32'(ch4), 32'd0);

        // 3-channel instance: sparse requests and wrap at num_ch
        rst3 = 1'b0; v3 = 3'b100;
        #1;
        check("n3_ready_ch2", 32'(ordy3), 32'b100);
        tick();
        check("n3_ch2", 32'(ch3), 32'd2);
        check("n3_data2", 32'(od3), 32'hA2);
        v3 = 3'b011;
        tick();
        check("n3_wrap_ch0", 32'(ch3), 32'd0);
        check("n3_wrap_valid", 32'(ov3), 32'd1);
        tick();
        check("n3_ch1", 32'(ch3), 32'd1);
        check("n3_data1", 32'(od3), 32'hA1);

        // Fixed mode with an out-of-range select never grants
        mode3 = 1'b0; sel3 = 2'd3; v3 = 3'b111;
        #1;
        check("n3_oor_ready", 32'(ordy3), 32'b000);
        tick();
        check("n3_oor_valid", 32'(ov3), 32'd0);
        check("n3_oor_hold_ch", 32'(ch3), 32'd1);
        sel3 = 2'd1;
        tick();
        check("n3_fix1_ch", 32'(ch3), 32'd1);
        check("n3_fix1_valid", 32'(ov3), 32'd1);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Packet lock: channel 1 sends 3 beats, channel 0 waits
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0; mode4 = 1'b1; rdy4 = 1'b1;
        v4 = 4'b0010; last4 = 4'b0000;
        tick();
        check("lk_b1_ch", 32'(ch4), 32'd1);
        check("lk_b1_last", 32'(olast4), 32'd0);
        v4 = 4'b0011;
        tick();
        check("lk_b2_ch", 32'(ch4), 32'd1);
        check("lk_b2_last", 32'(olast4), 32'd0);
        last4 = 4'b0010;
        tick();
        check("lk_b3_ch", 32'(ch4), 32'd1);
        check("lk_b3_last", 32'(olast4), 32'd1);
        last4 = 4'b0000;
        tick();
        check("lk_after_ch", 32'(ch4), 32'd0);
        check("lk_after_last", 32'(olast4), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_mux_n_to_one.md
Name: stream_mux_n_to_one

Overview:
- Parametrised successor to the fixed 4:1 combinational mux: selects one of num_ch input streams onto a single registered output stream with valid/ready handshake.
- Two arbitration modes, selected at run time: fixed select (mux-like) and round-robin.
- Sits between multiple producers and one consumer, for example sensor channels into a shared UART/processing path.

Parameters:
- bit_width, 8, data width per channel
- num_ch, 4, number of input channels (>=2)
- sel_width, $clog2(num_ch), width of select/channel-index fields (derived; do not override)

Ports:
- i_Clk  input  1  system clock, all logic on rising edge
- i_Reset  input  1  synchronous, active-high reset
- i_Data  input  num_ch*bit_width  channel k occupies bits [k*bit_width +: bit_width]
- i_Valid  input  num_ch  per-channel valid
- o_Ready  output  num_ch  per-channel ready (combinational)
- i_Mode  input  1  0 = fixed select, 1 = round-robin
- i_Sel  input  sel_width  channel used in fixed mode
- o_Data  output  bit_width  registered output data
- o_Valid  output  1  registered output valid
- o_Ch  output  sel_width  index of channel that sourced o_Data
- i_Ready  input  1  downstream ready

Behaviour:
- Clock and reset: one clock i_Clk; i_Reset is synchronous, active-high.
- Reset values: o_Valid=0, o_Data=0, o_Ch=0, round-robin pointer rr_ptr=0. o_Ready=all 0 while i_Reset=1.
- Load enable: load_en = !o_Valid || i_Ready. Output register updates only when load_en=1.
- Grant is combinational each cycle:
  - Fixed mode: grant = i_Sel if i_Sel < num_ch and i_Valid[i_Sel]=1. Otherwise no grant, even if other channels are valid. Out-of-range i_Sel never grants.
  - Round-robin mode: grant = first k with i_Valid[k]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo num_ch. No valid channel means no grant.
- o_Ready[k] = load_en && grant==k. At most one bit is set per cycle.
- Transfer on channel k: i_Valid[k] && o_Ready[k]. Next cycle o_Data=channel k data, o_Ch=k, o_Valid=1. Latency is 1 cycle from accepted input to o_Valid.
- load_en=1 with no grant: o_Valid<=0; o_Data and o_Ch hold their values.
- Output handshake: the beat is consumed when o_Valid && i_Ready. In the same cycle the register may reload a new beat, giving full throughput of 1 beat/cycle.
- Backpressure: o_Valid=1 and i_Ready=0 → o_Data, o_Ch and o_Valid are held stable and o_Ready=0.
- rr_ptr updates only on a transfer in round-robin mode: rr_ptr <= (k==num_ch-1) ? 0 : k+1. It is unchanged in fixed mode.
- Changing i_Mode or i_Sel affects only the next arbitration. A beat already held in the output register is never altered.
- Reset asserted mid-operation drops any held beat. o_Valid=0 on the following cycle and rr_ptr returns to 0.
- Arithmetic: all channel-index arithmetic is sel_width wide and wraps explicitly at num_ch, not at 2**sel_width, so num_ch that are not a power of two work correctly.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Enabled:
  - Extra input i_Last [num_ch-1:0] and extra output o_Last 1; o_Last is registered alongside o_Data with reset value 0.
  - After a transfer from channel k with i_Last[k]=0, the grant stays locked to k regardless of i_Mode and i_Sel until a transfer with i_Last[k]=1.
  - rr_ptr advances only on that final beat.
  - Reset clears the lock.
- Disabled: ports absent; every beat is arbitrated independently.

Decomposition:
- Shared package stream_mux_pkg holds:
  - the mode encoding constants MODE_FIXED=1'b0 and MODE_RR=1'b1
  - a function computing the next channel index with wrap at num_ch
- Natural sub-module: rr_arbiter, a purely combinational priority search from rr_ptr returning grant index and grant-valid. It is reused in fixed mode by masking the request vector to i_Sel.

Test Plan:
- Reset: hold i_Reset for 3 cycles with all i_Valid=1 → o_Valid=0, o_Data=0, o_Ready=0000 throughout. First beat appears 1 cycle after i_Reset=0.
- Fixed mode: i_Mode=0, i_Sel=2, channels 0..3 valid with data 0x10/0x20/0x30/0x40, i_Ready=1 → o_Data=0x30 and o_Ch=2 every cycle; o_Ready=0100.
- Round-robin fairness: i_Mode=1, all channels valid, i_Ready=1 → o_Ch sequence 0,1,2,3,0,1 and o_Valid continuously 1.
- Backpressure: o_Valid=1, o_Data=0x20, then i_Ready=0 for 4 cycles → o_Data/o_Ch held stable and o_Ready=0000. Next beat arrives the cycle after i_Ready=1.
- Sparse and wrap: num_ch=3, i_Mode=1, only channel 2 valid then only channel 0 valid → grants 2 then 0, rr_ptr wraps to 0 (not 3). Out-of-range i_Sel=3 in fixed mode → o_Valid=0.
- Lock (STREAM_MUX_PKT_LOCK_EN): channel 1 sends a 3-beat packet with i_Last=0,0,1 while channel 0 is also valid, round-robin mode → o_Ch=1,1,1, then 0; o_Last=1 only on the third beat.
